// File: rtl/thermal_pkg.sv
// Shared level encodings for the thermal monitor and the clock-throttle
// logic, plus the threshold classifier used on every evaluated sample.
package thermal_pkg;

  localparam int LEVEL_W = 3;

  // Codes 3'b100..3'b111 are reserved and never driven.
  typedef enum logic [LEVEL_W-1:0] {
    LVL_EQ    = 3'b000,
    LVL_SMALL = 3'b001,
    LVL_LG    = 3'b010,
    LVL_EXT   = 3'b011
  } level_t;

  // Map a sensor code onto a level given the three lower bounds.
  function automatic level_t classify(
    input logic [7:0] t,
    input logic [7:0] t_small,
    input logic [7:0] t_lg,
    input logic [7:0] t_ext
  );
    level_t lvl;
    if (t >= t_ext) begin
      lvl = LVL_EXT;
    end else if (t >= t_lg) begin
      lvl = LVL_LG;
    end else if (t >= t_small) begin
      lvl = LVL_SMALL;
    end else begin
      lvl = LVL_EQ;
    end
    return lvl;
  endfunction

endpackage

// File: rtl/therm_wdog.sv
// Sample watchdog: counts cycles since the last kick, saturating.
// expired is asserted on the cycle whose edge brings the count to
// WDOG_CYCLES (and stays asserted while saturated), so the owner can
// register the fault on that same edge.
module therm_wdog #(
  parameter int WDOG_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic kick,
  output logic expired
);

  localparam int CW = $clog2(WDOG_CYCLES + 1);

  logic [CW-1:0] cnt_reg;

  // Idle-cycle counter: cleared by reset or a kick, otherwise saturating count.
  always_ff @(posedge clk) begin
    if (rst || kick) begin
      cnt_reg <= '0;
    end else if (cnt_reg != CW'(WDOG_CYCLES)) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign expired = (cnt_reg >= CW'(WDOG_CYCLES - 1));

endmodule

// File: rtl/thermal_state_monitor.sv
// Thermal state monitor: classifies sensor samples into four levels with
// upward-immediate / downward-hysteresis candidates, debounces level changes,
// bypasses debounce for critical samples and forces EXT on sensor silence.
// Optional feature: define THERM_AVG_EN to evaluate the mean of the last
// four accepted samples instead of the raw sample (critical check stays raw).
module thermal_state_monitor
  import thermal_pkg::*;
#(
  parameter logic [7:0] T_SMALL     = 8'd60,
  parameter logic [7:0] T_LG        = 8'd80,
  parameter logic [7:0] T_EXT       = 8'd100,
  parameter logic [7:0] T_CRIT      = 8'd120,
  parameter int         HYST        = 4,
  parameter int         DEBOUNCE    = 3,
  parameter int         WDOG_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_valid,
  input  logic [7:0] temp_raw,
  output logic [2:0] temp_st,
  output logic       temp_st_chg,
  output logic       crit,
  output logic       sensor_fault
);

  level_t     level_reg, level_next;
  level_t     pend_reg, pend_next;
  logic [3:0] cnt_reg, cnt_next;
  logic       crit_reg, crit_next;
  logic       fault_reg, fault_next;
  logic       chg_reg, chg_next;

  logic [7:0] t_eval;
  logic [8:0] hyst_sum;
  logic [7:0] t_hyst;
  level_t     up, dn, cand;
  logic       wdog_expired;

`ifdef THERM_AVG_EN
  // tap[0] is the incoming sample, tap[1..3] the three previous accepted ones.
  logic [7:0] tap [4];
  logic [1:0] acc_reg;
  logic [9:0] avg_sum;

  assign tap[0] = temp_raw;

  for (genvar gi = 0; gi < 3; gi++) begin : g_hist
    logic [7:0] hist_reg;
    // Shift the sample history on every accepted sample.
    always_ff @(posedge clk) begin
      if (rst) begin
        hist_reg <= '0;
      end else if (sample_valid) begin
        hist_reg <= tap[gi];
      end
    end
    assign tap[gi+1] = hist_reg;
  end

  // Count accepted samples (saturating at 3 previous) so the mean is only
  // used once four real samples exist.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg <= '0;
    end else if (sample_valid && acc_reg != 2'd3) begin
      acc_reg <= acc_reg + 2'd1;
    end
  end

  assign avg_sum = {2'b00, tap[0]} + {2'b00, tap[1]} + {2'b00, tap[2]} + {2'b00, tap[3]};
  assign t_eval  = (acc_reg == 2'd3) ? avg_sum[9:2] : temp_raw;
`else
  assign t_eval = temp_raw;
`endif

  // Downward candidate uses the sample raised by the hysteresis, saturated.
  assign hyst_sum = {1'b0, t_eval} + 9'(HYST);
  assign t_hyst   = hyst_sum[8] ? 8'hFF : hyst_sum[7:0];
  assign up       = classify(t_eval, T_SMALL, T_LG, T_EXT);
  assign dn       = classify(t_hyst, T_SMALL, T_LG, T_EXT);

  therm_wdog #(
    .WDOG_CYCLES(WDOG_CYCLES)
  ) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .kick   (sample_valid),
    .expired(wdog_expired)
  );

  // Candidate: rise immediately on the raw class, fall only past hysteresis.
  always_comb begin
    cand = level_reg;
    if (up > level_reg) begin
      cand = up;
    end else if (dn < level_reg) begin
      cand = dn;
    end
  end

  // Next-state: critical bypass, debounce, and watchdog forcing.
  always_comb begin
    logic [3:0] cnt_inc;
    level_next = level_reg;
    pend_next  = pend_reg;
    cnt_next   = cnt_reg;
    crit_next  = crit_reg;
    fault_next = fault_reg;
    chg_next   = 1'b0;
    cnt_inc    = 4'd0;

    if (sample_valid) begin
      fault_next = 1'b0;
      if (temp_raw >= T_CRIT) begin
        crit_next  = 1'b1;
        level_next = LVL_EXT;
        cnt_next   = 4'd0;
        chg_next   = (level_reg != LVL_EXT);
      end else begin
        crit_next = 1'b0;
        if (cand == level_reg) begin
          cnt_next = 4'd0;
        end else begin
          cnt_inc   = (cand == pend_reg) ? (cnt_reg + 4'd1) : 4'd1;
          pend_next = cand;
          if (cnt_inc >= 4'(DEBOUNCE)) begin
            level_next = cand;
            chg_next   = 1'b1;
            cnt_next   = 4'd0;
          end else begin
            cnt_next = cnt_inc;
          end
        end
      end
    end else if (wdog_expired) begin
      fault_next = 1'b1;
      level_next = LVL_EXT;
      cnt_next   = 4'd0;
      chg_next   = (level_reg != LVL_EXT);
    end
  end

  // State and output registers; reset wins over any sample in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_reg <= LVL_EQ;
      pend_reg  <= LVL_EQ;
      cnt_reg   <= 4'd0;
      crit_reg  <= 1'b0;
      fault_reg <= 1'b0;
      chg_reg   <= 1'b0;
    end else begin
      level_reg <= level_next;
      pend_reg  <= pend_next;
      cnt_reg   <= cnt_next;
      crit_reg  <= crit_next;
      fault_reg <= fault_next;
      chg_reg   <= chg_next;
    end
  end

  assign temp_st      = level_reg;
  assign temp_st_chg  = chg_reg;
  assign crit         = crit_reg;
  assign sensor_fault = fault_reg;

endmodule

// File: tb/tb_thermal_state_monitor.sv
// Bench for thermal_state_monitor: directed vector table, hand-written
// watchdog sequences, and randomized traffic against a behavioural model.
module tb_thermal_state_monitor;

  localparam int T_SMALL  = 60;
  localparam int T_LG     = 80;
  localparam int T_EXT    = 100;
  localparam int T_CRIT   = 120;
  localparam int HYST     = 4;
  localparam int DEBOUNCE = 3;
  localparam int WDOG     = 1024;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sample_valid = 1'b0;
  logic [7:0] temp_raw = 8'd0;
  logic [2:0] temp_st;
  logic       temp_st_chg;
  logic       crit;
  logic       sensor_fault;

  int checks = 0;
  int failures = 0;

  thermal_state_monitor dut (
    .clk         (clk),
    .rst         (rst),
    .sample_valid(sample_valid),
    .temp_raw    (temp_raw),
    .temp_st     (temp_st),
    .temp_st_chg (temp_st_chg),
    .crit        (crit),
    .sensor_fault(sensor_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       r;
    bit       v;
    int       t;
    bit [2:0] st;
    bit       chg;
    bit       cr;
    bit       flt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit r, input bit v, input int t, input bit [2:0] st,
                     input bit chg, input bit cr, input bit flt);
    vec_t e;
    e.r = r; e.v = v; e.t = t; e.st = st; e.chg = chg; e.cr = cr; e.flt = flt;
    vecs.push_back(e);
  endtask

  // Drive one cycle of inputs, then step past the edge to the sampling point.
  task automatic cycle(input bit r, input bit v, input int t);
    rst = r;
    sample_valid = v;
    temp_raw = 8'(t);
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input bit [2:0] st, input bit chg,
                       input bit cr, input bit flt);
    checks++;
    if (temp_st !== st || temp_st_chg !== chg || crit !== cr || sensor_fault !== flt) begin
      failures++;
      $display("FAIL %s: got st=%0d chg=%0b crit=%0b fault=%0b expected st=%0d chg=%0b crit=%0b fault=%0b",
               name, temp_st, temp_st_chg, crit, sensor_fault, st, chg, cr, flt);
    end else begin
      $display("ok   %s: st=%0d chg=%0b crit=%0b fault=%0b", name, temp_st, temp_st_chg, crit, sensor_fault);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  int m_level, m_pend, m_run, m_idle;
  bit m_crit, m_fault, m_chg;

  function automatic int lvl_of(input int t);
    if (t >= T_EXT) return 3;
    if (t >= T_LG) return 2;
    if (t >= T_SMALL) return 1;
    return 0;
  endfunction

  task automatic model_step(input bit r, input bit v, input int raw);
    int old, up, dn, want, th;
    old = m_level;
    if (r) begin
      m_level = 0; m_pend = 0; m_run = 0; m_idle = 0;
      m_crit = 0; m_fault = 0; m_chg = 0;
      return;
    end
    if (v) begin
      m_idle = 0;
      m_fault = 0;
      if (raw >= T_CRIT) begin
        m_level = 3;
        m_crit = 1;
        m_run = 0;
      end else begin
        m_crit = 0;
        th = (raw + HYST > 255) ? 255 : raw + HYST;
        up = lvl_of(raw);
        dn = lvl_of(th);
        if (up > m_level) want = up;
        else if (dn < m_level) want = dn;
        else want = m_level;
        if (want == m_level) begin
          m_run = 0;
        end else begin
          if (want == m_pend) m_run++;
          else begin
            m_pend = want;
            m_run = 1;
          end
          if (m_run >= DEBOUNCE) begin
            m_level = want;
            m_run = 0;
          end
        end
      end
    end else begin
      if (m_idle < WDOG) m_idle++;
      if (m_idle >= WDOG) begin
        m_fault = 1;
        m_level = 3;
        m_run = 0;
      end
    end
    m_chg = (m_level != old);
  endtask

  function automatic int pick_temp();
    case ($urandom_range(0, 5))
      0: return $urandom_range(50, 68);
      1: return $urandom_range(72, 88);
      2: return $urandom_range(92, 108);
      3: return $urandom_range(114, 126);
      default: return $urandom_range(0, 255);
    endcase
  endfunction

  initial begin
    // ---------------- directed table ----------------
    //   rst v  temp  st chg crit flt
    add(1, 0,   0,   0, 0, 0, 0);  // reset state
    add(0, 1,  70,   0, 0, 0, 0);
    add(0, 1,  70,   0, 0, 0, 0);
    add(0, 1,  70,   1, 1, 0, 0);  // SMALL after 3rd sample
    add(0, 1,  85,   1, 0, 0, 0);
    add(0, 1,  85,   1, 0, 0, 0);
    add(0, 1,  85,   2, 1, 0, 0);  // LG
    add(0, 1,  78,   2, 0, 0, 0);  // 78+4 keeps LG
    add(0, 1,  78,   2, 0, 0, 0);
    add(0, 1,  78,   2, 0, 0, 0);
    add(0, 1,  75,   2, 0, 0, 0);
    add(0, 1,  75,   2, 0, 0, 0);
    add(0, 1,  75,   1, 1, 0, 0);  // falls to SMALL
    add(1, 0,   0,   0, 0, 0, 0);
    add(0, 1,  85,   0, 0, 0, 0);
    add(0, 1,  85,   0, 0, 0, 0);
    add(0, 1,  50,   0, 0, 0, 0);  // interruption clears the count
    add(0, 1,  85,   0, 0, 0, 0);
    add(0, 1,  85,   0, 0, 0, 0);
    add(0, 1,  85,   2, 1, 0, 0);  // LG on 6th sample
    add(1, 0,   0,   0, 0, 0, 0);
    add(0, 1, 119,   0, 0, 0, 0);  // just below critical
    add(0, 1, 120,   3, 1, 1, 0);  // exactly critical
    add(0, 1,  90,   3, 0, 0, 0);  // crit clears, stays EXT
    add(0, 1, 125,   3, 0, 1, 0);  // already EXT: no pulse
    add(0, 1,  99,   3, 0, 0, 0);  // 99+4 keeps EXT
    add(0, 1,  95,   3, 0, 0, 0);
    add(0, 1,  95,   3, 0, 0, 0);
    add(0, 1,  95,   2, 1, 0, 0);  // debounced exit from EXT
    add(1, 1, 125,   0, 0, 0, 0);  // reset overrides sample
    add(0, 1,  90,   0, 0, 0, 0);
    add(0, 1,  90,   0, 0, 0, 0);
    add(1, 0,   0,   0, 0, 0, 0);  // reset mid-debounce
    add(0, 1,  90,   0, 0, 0, 0);  // no change after one sample
    add(0, 1,  90,   0, 0, 0, 0);
    add(0, 1,  90,   2, 1, 0, 0);
    add(0, 0,   0,   2, 0, 0, 0);
    add(0, 1,  59,   2, 0, 0, 0);
    add(0, 0,   0,   2, 0, 0, 0);  // idle does not break the count
    add(0, 1,  59,   2, 0, 0, 0);
    add(0, 1,  59,   1, 1, 0, 0);
    add(0, 1,  56,   1, 0, 0, 0);  // 56+4 keeps SMALL
    add(0, 1,  55,   1, 0, 0, 0);

    foreach (vecs[i]) begin
      cycle(vecs[i].r, vecs[i].v, vecs[i].t);
      check($sformatf("vec%0d", i), vecs[i].st, vecs[i].chg, vecs[i].cr, vecs[i].flt);
    end

    // ---------------- watchdog expiry and recovery ----------------
    cycle(1, 0, 0);
    cycle(0, 1, 70);
    for (int i = 0; i < WDOG - 1; i++) cycle(0, 0, 0);
    check("wdog_before", 0, 0, 0, 0);
    cycle(0, 0, 0);
    check("wdog_expire", 3, 1, 0, 1);
    cycle(0, 0, 0);
    check("wdog_hold", 3, 0, 0, 1);
    cycle(0, 1, 30);
    check("wdog_clear", 3, 0, 0, 0);
    cycle(0, 1, 30);
    check("wdog_rec2", 3, 0, 0, 0);
    cycle(0, 1, 30);
    check("wdog_rec3", 0, 1, 0, 0);

    // ---------------- sample coinciding with expiry ----------------
    for (int i = 0; i < WDOG - 1; i++) cycle(0, 0, 0);
    cycle(0, 1, 30);
    check("coincide", 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) cycle(0, 0, 0);
    check("coincide_idle", 0, 0, 0, 0);

    // ---------------- randomized traffic vs model ----------------
    cycle(1, 0, 0);
    model_step(1, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      bit r, v;
      int t;
      if (n == 1500) begin
        for (int k = 0; k < WDOG + 20; k++) begin
          cycle(0, 0, 0);
          model_step(0, 0, 0);
        end
        check("rnd_gap", 3'(m_level), m_chg, m_crit, m_fault);
      end
      r = ($urandom_range(0, 199) == 0);
      v = ($urandom_range(0, 9) < 6);
      t = pick_temp();
      cycle(r, v, t);
      model_step(r, v, t);
      check($sformatf("rnd%0d r=%0b v=%0b t=%0d", n, r, v, t),
            3'(m_level), m_chg, m_crit, m_fault);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
